// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants and types for the RTC scan controller
package rtc_pkg;

  localparam int NUM_REGS = 10;
  localparam logic [3:0] IDLE_INDEX = 4'hF;

  // Scan index -> RTC register address (time/date block, then timer block)
  localparam logic [7:0] RTC_ADDR_MAP [0:NUM_REGS-1] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
    8'h41, 8'h42, 8'h43
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_FINISH
  } state_t;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_t;

endpackage

// File: rtl/rtc_scan_controller_if.sv
// rtl/rtc_scan_controller_if.sv - req/done handshake to the RTC bus driver
interface rtc_scan_controller_if;

  logic       bus_req;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_done;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata, bus_done
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_rdata, bus_done
  );

endinterface

// File: rtl/rtc_addr_rom.sv
// rtl/rtc_addr_rom.sv - scan index to RTC register address lookup
module rtc_addr_rom
  import rtc_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] addr
);

  // Look up the register address; indices past the last register map to 0
  always_comb begin
    addr = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) addr = RTC_ADDR_MAP[i];
    end
  end

endmodule

// File: rtl/rtc_scan_controller.sv
// rtl/rtc_scan_controller.sv - sequences periodic RTC read scans and on-demand write scans
module rtc_scan_controller
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_write,
  rtc_scan_controller_if.master        bus,
  output logic [3:0]                   mem_addr,
  output logic                         mem_we,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  output logic                         busy,
  output logic                         scan_done,
  output logic                         err
);

  state_t      state;
  state_t      state_next;
  mode_t       mode;
  logic [3:0]  idx;
  logic [31:0] refresh_cnt;
  logic [31:0] timeout_cnt;
  logic        write_pending;
  logic [7:0]  rdata_q;
  logic        req_q;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        err_q;
  logic [7:0]  map_addr;

  logic        want_write;
  logic        refresh_hit;
  logic        launch;
  logic        timed_out;
  logic        last_idx;

  rtc_addr_rom u_addr_rom (
    .idx  (idx),
    .addr (map_addr)
  );

  // A pulse arriving in the launch cycle counts, so writes beat a coincident refresh
  assign want_write  = write_pending | start_write;
  assign refresh_hit = (refresh_cnt == 32'(REFRESH_CYCLES - 1));
  assign launch      = (state == ST_IDLE) && (want_write || refresh_hit);
  assign timed_out   = (state == ST_WAIT) && !bus.bus_done &&
                       (timeout_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign last_idx    = (idx == 4'(NUM_REGS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (launch) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.bus_done)   state_next = ST_STORE;
        else if (timed_out) state_next = ST_IDLE;
      end
      ST_STORE:  state_next = last_idx ? ST_FINISH : ST_LOAD;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Scan bookkeeping: index, mode, refresh/timeout counters, pending write, captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= 4'd0;
      mode          <= MODE_READ;
      refresh_cnt   <= 32'd0;
      timeout_cnt   <= 32'd0;
      write_pending <= 1'b0;
      rdata_q       <= 8'h00;
    end else begin
      if (launch) begin
        idx         <= 4'd0;
        refresh_cnt <= 32'd0;
        mode        <= want_write ? MODE_WRITE : MODE_READ;
      end else if (state == ST_IDLE) begin
        refresh_cnt <= refresh_cnt + 32'd1;
      end else if (timed_out) begin
        refresh_cnt <= 32'd0;
      end

      if (launch && want_write) write_pending <= 1'b0;
      else if (start_write)     write_pending <= 1'b1;

      if (state == ST_STORE && !last_idx) idx <= idx + 4'd1;

      if (state == ST_ISSUE)     timeout_cnt <= 32'd0;
      else if (state == ST_WAIT) timeout_cnt <= timeout_cnt + 32'd1;

      if (state == ST_WAIT && bus.bus_done) rdata_q <= bus.bus_rdata;
    end
  end

  // Bus command registers: loaded in ISSUE and held stable while the request is up
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      req_q <= (state_next == ST_WAIT);
      err_q <= timed_out;
      if (state == ST_ISSUE) begin
        addr_q <= map_addr;
        wr_q   <= (mode == MODE_WRITE);
        if (mode == MODE_WRITE) wdata_q <= mem_rdata;
      end
    end
  end

  // State-decoded outputs
  always_comb begin
    mem_addr  = (state == ST_IDLE) ? IDLE_INDEX : idx;
    mem_we    = (state == ST_STORE) && (mode == MODE_READ);
    busy      = (state != ST_IDLE);
    scan_done = (state == ST_FINISH);
  end

  assign mem_wdata     = rdata_q;
  assign err           = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_rtc_scan_controller.sv
// tb/tb_rtc_scan_controller.sv - scoreboard bench for rtc_scan_controller
module tb_rtc_scan_controller;

  localparam int REFRESH = 20;
  localparam int TIMEOUT = 16;
  localparam int NREG    = 10;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         hi_len;
    int         gap;
  } txn_t;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } mw_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_write = 1'b0;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       scan_done;
  logic       err;

  logic       bm_done = 1'b0;
  logic       stray_done = 1'b0;
  logic [7:0] bm_rdata = 8'h00;
  logic [7:0] mem [0:NREG-1];

  txn_t exp_txn [$];
  mw_t  exp_mem [$];
  bit   exp_end [$];

  int         checks = 0;
  int         errors = 0;
  int         d_cur = 3;
  logic [7:0] salt = 8'hFF;
  logic [7:0] hang_addr = 8'h00;
  bit         mon_on = 1'b0;

  rtc_scan_controller_if bif ();

  assign bif.bus_done  = bm_done | stray_done;
  assign bif.bus_rdata = bm_rdata;
  assign mem_rdata     = (mem_addr < 4'd10) ? mem[mem_addr] : 8'h00;

  rtc_scan_controller #(
    .REFRESH_CYCLES (REFRESH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_write (start_write),
    .bus         (bif),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .scan_done   (scan_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] reg_addr(int i);
    return (i < 7) ? 8'(8'h21 + i) : 8'(8'h41 + (i - 7));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected traffic for one scan; ok=0 means the entry at 'last' never answers
  task automatic push_scan(input bit wr, input int last, input bit ok);
    txn_t t;
    mw_t  m;
    for (int i = 0; i <= last; i++) begin
      t.wr     = wr;
      t.addr   = reg_addr(i);
      t.wdata  = wr ? mem[i] : 8'h00;
      t.hi_len = (ok || i < last) ? d_cur + 1 : TIMEOUT;
      t.gap    = (i == 0) ? 0 : d_cur + 4;
      exp_txn.push_back(t);
      if (!wr && (ok || i < last)) begin
        m.idx  = 4'(i);
        m.data = reg_addr(i) ^ salt;
        exp_mem.push_back(m);
      end
    end
    exp_end.push_back(ok);
  endtask

  task automatic wait_end();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(scan_done || err) && n < 3000);
    chk("scan_end_seen", 32'(scan_done | err), 1);
  endtask

  task automatic measure_idle(input int exp, input bit stray);
    int n = 0;
    @(negedge clk);
    while (!busy && n < 500) begin
      n++;
      stray_done = stray && (n == 3 || n == 7);
      @(negedge clk);
    end
    stray_done = 1'b0;
    if (stray && busy) begin
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
    end
    chk("idle_len", n, exp);
  endtask

  task automatic pulse_write();
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NREG; i++) mem[i] = 8'($urandom);
  endtask

  // Memory model: accept writes strobed by the controller
  initial begin
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 4'd10) mem[mem_addr] = mem_wdata;
    end
  end

  // Bus driver model: answers d_cur cycles after the request rises, never for hang_addr
  initial begin
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (bif.bus_req && !reset) begin
        a = bif.bus_addr;
        if (a != hang_addr) begin
          repeat (d_cur) @(negedge clk);
          bm_done  = 1'b1;
          bm_rdata = a ^ salt;
          @(negedge clk);
          bm_done  = 1'b0;
        end else begin
          while (bif.bus_req) @(negedge clk);
        end
      end
    end
  end

  // Monitor: compares observed transactions, memory writes and scan endings with the queues
  initial begin
    txn_t cur;
    mw_t  m;
    bit   e;
    int   hi = 0;
    int   cyc = 0;
    int   last_rise = 0;
    logic req_prev = 1'b0;
    cur = '{1'b0, 8'h00, 8'h00, 0, 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_on) begin
        if (bif.bus_req && !req_prev) begin
          if (exp_txn.size() == 0) begin
            chk("txn_unexpected", exp_txn.size(), 1);
          end else begin
            cur = exp_txn.pop_front();
            chk("bus_wr", bif.bus_wr, cur.wr);
            chk("bus_addr", bif.bus_addr, cur.addr);
            if (cur.wr) chk("bus_wdata", bif.bus_wdata, cur.wdata);
            if (cur.gap != 0) chk("entry_latency", cyc - last_rise, cur.gap);
          end
          last_rise = cyc;
          hi = 1;
        end else if (bif.bus_req) begin
          hi++;
          chk("addr_stable", bif.bus_addr, cur.addr);
          chk("wr_stable", bif.bus_wr, cur.wr);
          if (cur.wr) chk("wdata_stable", bif.bus_wdata, cur.wdata);
        end
        if (!bif.bus_req && req_prev) chk("req_high_len", hi, cur.hi_len);
        if (mem_we) begin
          if (exp_mem.size() == 0) begin
            chk("memwe_unexpected", exp_mem.size(), 1);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_idx", mem_addr, m.idx);
            chk("mem_data", mem_wdata, m.data);
          end
        end
        if (scan_done || err) begin
          if (exp_end.size() == 0) begin
            chk("end_unexpected", exp_end.size(), 1);
          end else begin
            e = exp_end.pop_front();
            chk("end_kind_done", scan_done, e);
            chk("end_kind_err", err, !e);
            if (err) begin
              chk("err_after_req", req_prev, 1);
              chk("err_req_low", bif.bus_req, 0);
              chk("err_busy", busy, 0);
            end
          end
        end
      end
      req_prev = mon_on ? bif.bus_req : 1'b0;
    end
  end

  // Stimulus
  initial begin
    int n;
    int k;
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;

    // Reset, then abort the first scan mid-WAIT at index 2
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!(bif.bus_req && bif.bus_addr == 8'h23) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx2", bif.bus_addr, 8'h23);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_bus_req", bif.bus_req, 0);
    chk("rst_bus_wr", bif.bus_wr, 0);
    chk("rst_bus_addr", bif.bus_addr, 8'h00);
    chk("rst_bus_wdata", bif.bus_wdata, 8'h00);
    chk("rst_mem_addr", mem_addr, 4'hF);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed periodic read: done 3 cycles after req, rdata = addr ^ FF
    mon_on = 1'b1;
    d_cur = 3;
    salt = 8'hFF;
    push_scan(1'b0, NREG - 1, 1'b1);
    measure_idle(REFRESH - 1, 1'b0);
    wait_end();
    chk("mem0_after_read", mem[0], 8'hDE);
    chk("mem9_after_read", mem[9], 8'hBC);

    // Random read with stray bus_done in IDLE and LOAD
    d_cur = $urandom_range(1, 5);
    salt = 8'($urandom);
    push_scan(1'b0, NREG - 1, 1'b1);
    measure_idle(REFRESH, 1'b1);
    wait_end();

    // Directed write scan with mem = idx*0x11
    for (int i = 0; i < NREG; i++) mem[i] = 8'(i * 8'h11);
    push_scan(1'b1, NREG - 1, 1'b1);
    @(negedge clk);
    pulse_write();
    wait_end();

    // Arbitration: start_write lands in the refresh-hit cycle, then two merged pulses
    randomize_mem();
    d_cur = $urandom_range(1, 5);
    salt = 8'($urandom);
    push_scan(1'b1, NREG - 1, 1'b1);
    push_scan(1'b1, NREG - 1, 1'b1);
    push_scan(1'b0, NREG - 1, 1'b1);
    repeat (REFRESH) @(negedge clk);
    pulse_write();
    repeat (8) @(negedge clk);
    pulse_write();
    repeat (5) @(negedge clk);
    pulse_write();
    wait_end();
    wait_end();
    measure_idle(REFRESH, 1'b0);
    wait_end();

    // Timeout at index 4, then a clean scan from index 0
    d_cur = $urandom_range(1, 5);
    salt = 8'($urandom);
    hang_addr = 8'h25;
    push_scan(1'b0, 4, 1'b0);
    measure_idle(REFRESH, 1'b0);
    wait_end();
    hang_addr = 8'h00;
    salt = 8'($urandom);
    push_scan(1'b0, NREG - 1, 1'b1);
    measure_idle(REFRESH - 1, 1'b0);
    wait_end();

    // Random mix of read and write scans
    for (int r = 0; r < 4; r++) begin
      d_cur = $urandom_range(1, 5);
      salt = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        randomize_mem();
        push_scan(1'b1, NREG - 1, 1'b1);
        k = $urandom_range(1, 10);
        repeat (k) @(negedge clk);
        pulse_write();
      end else begin
        push_scan(1'b0, NREG - 1, 1'b1);
        measure_idle(REFRESH, 1'b0);
      end
      wait_end();
    end

    repeat (5) @(negedge clk);
    chk("txn_queue_empty", exp_txn.size(), 0);
    chk("mem_queue_empty", exp_mem.size(), 0);
    chk("end_queue_empty", exp_end.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
